// File: rtl/bandit_pkg.sv
// Shared definitions for the one-arm-bandit game sequencer: state codes,
// reel range and the per-reel step increments.
package bandit_pkg;

    typedef enum logic [3:0] {
        ST_WELCOME = 4'd0,
        ST_GAME    = 4'd1,
        ST_SCORE   = 4'd2,
        ST_ERROR   = 4'd3,
        ST_COIN    = 4'd4
    } state_t;

    localparam logic [3:0] REEL_MAX  = 4'd9;
    localparam logic [3:0] REEL1_INC = 4'd1;
    localparam logic [3:0] REEL2_INC = 4'd3;
    localparam logic [3:0] REEL3_INC = 4'd7;

    // Step increment for reel index 0..2 (reel1..reel3).
    function automatic logic [3:0] reel_inc(input int idx);
        case (idx)
            0:       return REEL1_INC;
            1:       return REEL2_INC;
            default: return REEL3_INC;
        endcase
    endfunction

    // Mod-10 add: a 5-bit sum folded back once, so inputs 0..9 stay 0..9.
    function automatic logic [3:0] reel_add(input logic [3:0] val, input logic [3:0] inc);
        logic [4:0] sum;
        sum = {1'b0, val} + {1'b0, inc};
        if (sum > {1'b0, REEL_MAX})
            sum = sum - 5'd10;
        return sum[3:0];
    endfunction

endpackage

// File: rtl/bandit_reel.sv
// One decimal reel. Steps by INC (mod 10) while unfrozen; freeze wins over a
// coincident step so a stopped reel keeps its pre-step value. clear zeroes the
// reel and releases the freeze at the start of a new game.
module bandit_reel
    import bandit_pkg::*;
#(
    parameter logic [3:0] INC = 4'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic       freeze,
    input  logic       clear,
    output logic [3:0] value
);

    logic frozen;

    // Reel value and frozen flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value  <= '0;
            frozen <= 1'b0;
        end else if (clear) begin
            value  <= '0;
            frozen <= 1'b0;
        end else if (freeze) begin
            frozen <= 1'b1;
        end else if (step && !frozen) begin
            value  <= reel_add(value, INC);
        end
    end

endmodule

// File: rtl/bandit_game_ctrl.sv
// Game sequencer for the one-arm bandit: coin credit, three spinning reels
// frozen by stop presses, hand-off to the score block and verdict handling.
// Optional feature: define BANDIT_AUTO_STOP_EN to freeze the next reel
// automatically after AUTO_STOP_CYCLES without a stop press.
module bandit_game_ctrl
    import bandit_pkg::*;
#(
    parameter int SPIN_CYCLES      = 8,
    parameter int SCORE_WAIT       = 64,
    parameter int ERR_CYCLES       = 32,
    parameter int MAX_CREDIT       = 9,
    parameter int AUTO_STOP_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_p,
    input  logic       start_p,
    input  logic       stop_p,
    input  logic       pass_p,
    input  logic       lose_p,
    output logic [3:0] state,
    output logic [3:0] number1,
    output logic [3:0] number2,
    output logic [3:0] number3,
    output logic       turn_p,
    output logic       score_reset,
    output logic [3:0] credit,
    output logic       error
);

    localparam int DIV_W   = $clog2(SPIN_CYCLES + 1);
    localparam int TMR_A   = (SCORE_WAIT > ERR_CYCLES) ? SCORE_WAIT : ERR_CYCLES;
    localparam int TMR_LIM = (TMR_A > AUTO_STOP_CYCLES) ? TMR_A : AUTO_STOP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_LIM + 1);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SPIN_CYCLES - 1);
    localparam logic [TMR_W-1:0] SCORE_LAST = TMR_W'(SCORE_WAIT - 1);
    localparam logic [TMR_W-1:0] ERR_LAST   = TMR_W'(ERR_CYCLES - 1);
    localparam logic [3:0]       CREDIT_MAX = 4'(MAX_CREDIT);

    state_t           state_q, state_d;
    logic [3:0]       credit_q, credit_d, credit_coin;
    logic [DIV_W-1:0] div_q, div_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [1:0]       stop_idx_q, stop_idx_d;
    logic             turn_d, score_reset_d, error_q;
    logic             coin_ok, stop_evt, auto_stop, tmr_run;
    logic             reel_step, reel_clear;
    logic [2:0]       reel_freeze;
    logic [2:0][3:0]  reel_val;

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c >= CREDIT_MAX) ? CREDIT_MAX : c + 4'd1;
    endfunction

`ifdef BANDIT_AUTO_STOP_EN
    localparam logic [TMR_W-1:0] AUTO_LAST = TMR_W'(AUTO_STOP_CYCLES - 1);
    assign auto_stop = (state_q == ST_GAME) && (tmr_q == AUTO_LAST);
    assign tmr_run   = (state_q == ST_GAME) || (state_q == ST_SCORE) || (state_q == ST_ERROR);
`else
    assign auto_stop = 1'b0;
    assign tmr_run   = (state_q == ST_SCORE) || (state_q == ST_ERROR);
`endif

    // Coins count everywhere but ERROR; a stop only matters while spinning.
    assign coin_ok  = coin_p && (state_q != ST_ERROR);
    assign stop_evt = (state_q == ST_GAME) && (stop_p || auto_stop);

    // Next-state, credit, divider and reel-control decode.
    always_comb begin
        state_d       = state_q;
        credit_coin   = coin_ok ? sat_inc(credit_q) : credit_q;
        credit_d      = credit_coin;
        div_d         = '0;
        stop_idx_d    = stop_idx_q;
        turn_d        = 1'b0;
        score_reset_d = 1'b0;
        reel_step     = 1'b0;
        reel_clear    = 1'b0;
        reel_freeze   = '0;

        case (state_q)
            ST_WELCOME: begin
                if (coin_p) begin
                    state_d       = ST_COIN;
                    score_reset_d = 1'b1;
                end else if (start_p && credit_q == '0) begin
                    state_d = ST_ERROR;
                end
            end
            ST_COIN: begin
                if (start_p) begin
                    if (credit_q != '0) begin
                        // Coin and start together cancel out, even at saturation.
                        state_d    = ST_GAME;
                        credit_d   = coin_ok ? credit_q : credit_q - 4'd1;
                        reel_clear = 1'b1;
                        stop_idx_d = '0;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_GAME: begin
                reel_step = (div_q == DIV_LAST);
                div_d     = reel_step ? '0 : div_q + 1'b1;
                if (stop_evt) begin
                    reel_freeze = 3'b001 << stop_idx_q;
                    stop_idx_d  = stop_idx_q + 2'd1;
                    if (stop_idx_q == 2'd2) begin
                        state_d = ST_SCORE;
                        turn_d  = 1'b1;
                        div_d   = '0;
                    end
                end
            end
            ST_SCORE: begin
                if (pass_p) begin
                    credit_d = sat_inc(credit_coin);
                    state_d  = ST_COIN;
                end else if (lose_p) begin
                    state_d = (credit_q != '0) ? ST_COIN : ST_WELCOME;
                end else if (tmr_q == SCORE_LAST) begin
                    state_d = ST_ERROR;
                end
            end
            ST_ERROR: begin
                credit_d = credit_q;
                if (tmr_q == ERR_LAST)
                    state_d = (credit_q != '0) ? ST_COIN : ST_WELCOME;
            end
            default: state_d = ST_WELCOME;
        endcase

        // One timer serves SCORE wait, ERROR hold and the auto-stop interval.
        if (state_d != state_q || stop_evt)
            tmr_d = '0;
        else if (tmr_run)
            tmr_d = tmr_q + 1'b1;
        else
            tmr_d = tmr_q;
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_WELCOME;
            credit_q    <= '0;
            div_q       <= '0;
            tmr_q       <= '0;
            stop_idx_q  <= '0;
            turn_p      <= 1'b0;
            score_reset <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            div_q       <= div_d;
            tmr_q       <= tmr_d;
            stop_idx_q  <= stop_idx_d;
            turn_p      <= turn_d;
            score_reset <= score_reset_d;
            error_q     <= (state_d == ST_ERROR);
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_reel
        bandit_reel #(.INC(reel_inc(i))) u_reel (
            .clk    (clk),
            .rst_n  (rst_n),
            .step   (reel_step),
            .freeze (reel_freeze[i]),
            .clear  (reel_clear),
            .value  (reel_val[i])
        );
    end

    assign state   = state_q;
    assign credit  = credit_q;
    assign error   = error_q;
    assign number1 = reel_val[0];
    assign number2 = reel_val[1];
    assign number3 = reel_val[2];

endmodule

// File: tb/tb_bandit_game_ctrl.sv
// Bench for bandit_game_ctrl: directed walk through the game flow followed by
// random pulses, all checked every cycle against a behavioural game model.
module tb_bandit_game_ctrl;

    localparam int SPIN = 2;
    localparam int SW   = 64;
    localparam int EC   = 32;
    localparam int MC   = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic coin_p = 1'b0, start_p = 1'b0, stop_p = 1'b0, pass_p = 1'b0, lose_p = 1'b0;
    logic [3:0] state, number1, number2, number3, credit;
    logic turn_p, score_reset, error;

    bandit_game_ctrl #(
        .SPIN_CYCLES(SPIN), .SCORE_WAIT(SW), .ERR_CYCLES(EC),
        .MAX_CREDIT(MC), .AUTO_STOP_CYCLES(256)
    ) dut (
        .clk(clk), .rst_n(rst_n), .coin_p(coin_p), .start_p(start_p),
        .stop_p(stop_p), .pass_p(pass_p), .lose_p(lose_p), .state(state),
        .number1(number1), .number2(number2), .number3(number3),
        .turn_p(turn_p), .score_reset(score_reset), .credit(credit), .error(error)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Game model: state code, credit, stops taken, cycles spent in GAME,
    // cycles spent in the current state, frozen reel values, pulse outputs.
    int m_state, m_credit, m_idx, m_g, m_tmr, m_turn, m_srst, m_err;
    int m_num [3];
    int inc [3] = '{1, 3, 7};

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // A spinning reel shows inc * (completed SPIN periods) mod 10.
    function automatic int shown(input int i);
        if (m_state == 1 && i >= m_idx)
            return (inc[i] * (m_g / SPIN)) % 10;
        return m_num[i];
    endfunction

    task automatic model_reset();
        m_state = 0; m_credit = 0; m_idx = 0; m_g = 0; m_tmr = 0;
        m_turn = 0; m_srst = 0; m_err = 0;
        m_num = '{0, 0, 0};
    endtask

    task automatic model_step(input bit c, input bit s, input bit t, input bit p, input bit l);
        int ns, nc;
        ns = m_state;
        nc = m_credit;
        m_turn = 0;
        m_srst = 0;
        if (c && m_state != 3)
            nc = (m_credit + 1 > MC) ? MC : m_credit + 1;
        case (m_state)
            0: if (c) begin ns = 4; m_srst = 1; end
               else if (s && m_credit == 0) ns = 3;
            4: if (s) begin
                   if (m_credit > 0) begin
                       ns = 1;
                       nc = c ? m_credit : m_credit - 1;
                       m_idx = 0;
                       m_num = '{0, 0, 0};
                   end else ns = 3;
               end
            1: if (t) begin
                   m_num[m_idx] = (inc[m_idx] * (m_g / SPIN)) % 10;
                   m_idx++;
                   if (m_idx == 3) begin ns = 2; m_turn = 1; end
               end
            2: if (p) begin nc = (nc + 1 > MC) ? MC : nc + 1; ns = 4; end
               else if (l) ns = (m_credit > 0) ? 4 : 0;
               else if (m_tmr == SW - 1) ns = 3;
            3: if (m_tmr == EC - 1) ns = (m_credit > 0) ? 4 : 0;
            default: ;
        endcase
        if (ns == 1) m_g = (m_state == 1) ? m_g + 1 : 0;
        m_tmr = (ns != m_state) ? 0 : m_tmr + 1;
        m_state = ns;
        m_credit = nc;
        m_err = (ns == 3) ? 1 : 0;
    endtask

    task automatic check_all();
        chk("state", int'(state), m_state);
        chk("credit", int'(credit), m_credit);
        chk("error", int'(error), m_err);
        chk("turn_p", int'(turn_p), m_turn);
        chk("score_reset", int'(score_reset), m_srst);
        chk("number1", int'(number1), shown(0));
        chk("number2", int'(number2), shown(1));
        chk("number3", int'(number3), shown(2));
    endtask

    // Drive one cycle of pulses (inputs change at negedge), then check after the edge.
    task automatic cyc(input bit c, input bit s, input bit t, input bit p, input bit l);
        coin_p = c; start_p = s; stop_p = t; pass_p = p; lose_p = l;
        model_step(c, s, t, p, l);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic play_stops(input int gap);
        for (int k = 0; k < 3; k++) begin
            idle(gap);
            cyc(0, 0, 1, 0, 0);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        @(negedge clk);
        check_all();

        // First round: coin, start, three spaced stops, pass.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        play_stops(9);
        idle(1);
        cyc(0, 0, 0, 1, 0);
        // Second round lost with no credit left -> WELCOME.
        cyc(0, 1, 0, 0, 0);
        play_stops(4);
        idle(2);
        cyc(0, 0, 0, 0, 1);
        // Both verdicts at once count as a pass.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        play_stops(3);
        idle(1);
        cyc(0, 0, 0, 1, 1);
        // Saturation, coin+start together, then SCORE timeout into ERROR.
        for (int k = 0; k < 10; k++) cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        play_stops(0);
        idle(SW + EC + 4);

        // Asynchronous reset in the middle of a game.
        cyc(0, 1, 0, 0, 0);
        idle(5);
        cyc(0, 0, 1, 0, 0);
        idle(3);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        // Start with no credit in WELCOME -> ERROR, then back to WELCOME.
        cyc(0, 1, 0, 0, 0);
        idle(EC + 4);

        // Random pulses on every input.
        for (int k = 0; k < 4000; k++) begin
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 39) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
